// File: rtl/compute_sequencer.sv
// Job sequencer for the compute array.
//
// A serial job runs the serial engine once. A systolic job preloads the
// weights, then loads 1..4 feature tiles. Each engine enable is a level that
// is held until its done input is sampled, the per-step timeout expires, or
// the job is aborted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; configuration is latched on start
// SER_RUN | serial engine enabled, waiting for serial_mode_done
// W_LOAD  | weight preloader enabled, waiting for weight_Preloader_done
// W_GAP   | one idle cycle between the weight preload and the first tile
// F_LOAD  | feature loader enabled for the current tile
// F_GAP   | one idle cycle after a tile; chooses the next tile or FIN
// FIN     | one-cycle job_done pulse
module compute_sequencer #(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            job_mode,
  input  logic [7:0]      serial_base,
  input  logic [5:0]      systolic_base,
  input  logic [5:0]      tile_stride,
  input  logic [1:0]      num_tiles_m1,
  input  logic [TO_W-1:0] timeout,
  input  logic            serial_mode_done,
  input  logic            weight_Preloader_done,
  input  logic            feature_Loader_done,
  output logic            serial_mode_en,
  output logic            Weight_Preloader_en,
  output logic            Feature_Loader_en,
  output logic            systolic_mode,
  output logic [1:0]      c_reg_sel,
  output logic            computation_mode_sel,
  output logic [7:0]      serial_mode_feature_baseaddr,
  output logic [5:0]      systolic_mode_feature_baseaddr,
  output logic            busy,
  output logic            job_done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SER_RUN = 3'd1,
    W_LOAD  = 3'd2,
    W_GAP   = 3'd3,
    F_LOAD  = 3'd4,
    F_GAP   = 3'd5,
    FIN     = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      tile_q, tile_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            msel_q, msel_d;
  logic [7:0]      ser_base_q, ser_base_d;
  logic [5:0]      addr_q, addr_d;
  logic [5:0]      stride_q, stride_d;
  logic [1:0]      ntm1_q, ntm1_d;
  logic            to_hit;

  // The step counter starts at 0 on entry, so reaching timeout-1 at an edge
  // means the enable has been high for exactly `timeout` cycles.
  assign to_hit = (to_q != '0) && (cnt_q == (to_q - TO_W'(1)));

  // Next-state logic: abort overrides everything except reset; done is
  // checked before the timeout so a simultaneous done still completes.
  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    cnt_d      = '0;
    to_d       = to_q;
    err_d      = err_q;
    msel_d     = msel_q;
    ser_base_d = ser_base_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    ntm1_d     = ntm1_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ser_base_d = serial_base;
            addr_d     = systolic_base;
            stride_d   = tile_stride;
            ntm1_d     = num_tiles_m1;
            to_d       = timeout;
            err_d      = 1'b0;
            tile_d     = 2'd0;
            msel_d     = job_mode;
            state_d    = job_mode ? W_LOAD : SER_RUN;
          end
        end
        SER_RUN: begin
          if (serial_mode_done) begin
            state_d = FIN;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        W_LOAD: begin
          if (weight_Preloader_done) begin
            state_d = W_GAP;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        W_GAP: begin
          tile_d  = 2'd0;
          state_d = F_LOAD;
        end
        F_LOAD: begin
          if (feature_Loader_done) begin
            state_d = F_GAP;
          end else if (to_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        F_GAP: begin
          if (tile_q < ntm1_q) begin
            tile_d  = tile_q + 2'd1;
            addr_d  = addr_q + stride_q;
            state_d = F_LOAD;
          end else begin
            state_d = FIN;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and latched-configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tile_q     <= 2'd0;
      cnt_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
      msel_q     <= 1'b0;
      ser_base_q <= 8'd0;
      addr_q     <= 6'd0;
      stride_q   <= 6'd0;
      ntm1_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      err_q      <= err_d;
      msel_q     <= msel_d;
      ser_base_q <= ser_base_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      ntm1_q     <= ntm1_d;
    end
  end

  // Outputs decode straight from registers, so each enable is one state.
  assign serial_mode_en                 = (state_q == SER_RUN);
  assign Weight_Preloader_en            = (state_q == W_LOAD);
  assign Feature_Loader_en              = (state_q == F_LOAD);
  assign systolic_mode                  = (state_q == F_LOAD);
  assign c_reg_sel                      = tile_q;
  assign computation_mode_sel           = msel_q;
  assign serial_mode_feature_baseaddr   = ser_base_q;
  assign systolic_mode_feature_baseaddr = addr_q;
  assign busy                           = (state_q != IDLE);
  assign job_done                       = (state_q == FIN);
  assign err                            = err_q;

endmodule

// File: tb/tb_compute_sequencer.sv
// Bench for compute_sequencer: a table of jobs plus hand-written abort and
// reset sequences. Each enable run and job_done pulse is checked against an
// expected-event queue filled when the job is launched.
module tb_compute_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, job_mode;
  logic [7:0] serial_base;
  logic [5:0] systolic_base, tile_stride;
  logic [1:0] num_tiles_m1;
  logic [7:0] timeout;
  logic       serial_mode_done, weight_Preloader_done, feature_Loader_done;
  logic       serial_mode_en, Weight_Preloader_en, Feature_Loader_en;
  logic       systolic_mode, computation_mode_sel, busy, job_done, err;
  logic [1:0] c_reg_sel;
  logic [7:0] serial_mode_feature_baseaddr;
  logic [5:0] systolic_mode_feature_baseaddr;

  always #5 clk = ~clk;

  compute_sequencer #(.TO_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .job_mode(job_mode),
    .serial_base(serial_base), .systolic_base(systolic_base),
    .tile_stride(tile_stride), .num_tiles_m1(num_tiles_m1), .timeout(timeout),
    .serial_mode_done(serial_mode_done),
    .weight_Preloader_done(weight_Preloader_done),
    .feature_Loader_done(feature_Loader_done),
    .serial_mode_en(serial_mode_en), .Weight_Preloader_en(Weight_Preloader_en),
    .Feature_Loader_en(Feature_Loader_en), .systolic_mode(systolic_mode),
    .c_reg_sel(c_reg_sel), .computation_mode_sel(computation_mode_sel),
    .serial_mode_feature_baseaddr(serial_mode_feature_baseaddr),
    .systolic_mode_feature_baseaddr(systolic_mode_feature_baseaddr),
    .busy(busy), .job_done(job_done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // kind: 0 serial run, 1 weight run, 2 feature run, 3 job_done pulse
  typedef struct {
    int kind; int addr; int csel; int msel; int len; int gap;
  } ev_t;
  ev_t exq[$];

  task automatic push_ev(input int kind, input int addr, input int csel,
                         input int msel, input int len, input int gap);
    ev_t e;
    e.kind = kind; e.addr = addr; e.csel = csel;
    e.msel = msel; e.len = len;  e.gap = gap;
    exq.push_back(e);
  endtask

  typedef struct {
    bit         mode;
    logic [7:0] sb;
    logic [5:0] yb;
    logic [5:0] st;
    logic [1:0] nt;
    logic [7:0] to;
    int         dly;
    bit         stray;
    bit         exp_err;
  } row_t;

  // Done responder: raises the active engine's done after resp_delay cycles
  // of enable (0 = never); with resp_stray the other dones are held high.
  int resp_delay = 0;
  bit resp_stray = 1'b0;
  int resp_cnt   = 0;
  always @(negedge clk) begin
    logic hit;
    if (serial_mode_en || Weight_Preloader_en || Feature_Loader_en) resp_cnt++;
    else resp_cnt = 0;
    hit = (resp_delay != 0) && (resp_cnt == resp_delay);
    serial_mode_done      = serial_mode_en      ? hit : resp_stray;
    weight_Preloader_done = Weight_Preloader_en ? hit : resp_stray;
    feature_Loader_done   = Feature_Loader_en   ? hit : resp_stray;
  end

  // Monitor: collapses each contiguous enable run into one event.
  bit mon_on  = 1'b0;
  bit run_act = 1'b0;
  int run_len, run_kind, run_addr, run_csel, run_msel, run_gap;
  int gap_cnt = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      ev_t e;
      chk("one_hot_enables",
          int'(serial_mode_en) + int'(Weight_Preloader_en) + int'(Feature_Loader_en) <= 1, 1);
      if (serial_mode_en || Weight_Preloader_en || Feature_Loader_en) begin
        if (!run_act) begin
          run_act = 1'b1; run_len = 0; run_gap = gap_cnt;
        end
        run_len++;
        run_kind = serial_mode_en ? 0 : (Weight_Preloader_en ? 1 : 2);
        run_addr = serial_mode_en ? int'(serial_mode_feature_baseaddr)
                                  : int'(systolic_mode_feature_baseaddr);
        run_csel = c_reg_sel;
        run_msel = computation_mode_sel;
        if (Feature_Loader_en) chk("systolic_mode_in_f", systolic_mode, 1);
        if (Weight_Preloader_en) chk("systolic_mode_in_w", systolic_mode, 0);
      end else begin
        if (run_act) begin
          run_act = 1'b0;
          gap_cnt = 1;
          if (exq.size() == 0) begin
            chk("unexpected_run_kind", run_kind, -1);
          end else begin
            e = exq.pop_front();
            chk("run_kind", run_kind, e.kind);
            chk("run_addr", run_addr, e.addr);
            chk("run_c_reg_sel", run_csel, e.csel);
            chk("run_mode_sel", run_msel, e.msel);
            chk("run_len", run_len, e.len);
            if (e.gap != 255) chk("run_gap", run_gap, e.gap);
          end
        end else if (gap_cnt < 1000) begin
          gap_cnt++;
        end
      end
      if (job_done) begin
        if (exq.size() == 0) chk("unexpected_job_done", 1, 0);
        else begin
          e = exq.pop_front();
          chk("job_done_kind", 3, e.kind);
        end
      end
    end
  end

  task automatic push_expect(input row_t r);
    int l;
    l = r.exp_err ? int'(r.to) : r.dly;
    if (!r.mode) begin
      push_ev(0, int'(r.sb), 0, 0, l, 255);
      if (!r.exp_err) push_ev(3, 0, 0, 0, 0, 255);
    end else begin
      push_ev(1, int'(r.yb), 0, 1, l, 255);
      if (!r.exp_err) begin
        for (int i = 0; i <= int'(r.nt); i++)
          push_ev(2, (int'(r.yb) + i * int'(r.st)) % 64, i, 1, r.dly, 1);
        push_ev(3, 0, 0, 0, 0, 255);
      end
    end
  endtask

  task automatic launch(input row_t r);
    resp_delay = r.dly;
    resp_stray = r.stray;
    @(negedge clk);
    job_mode = r.mode; serial_base = r.sb; systolic_base = r.yb;
    tile_stride = r.st; num_tiles_m1 = r.nt; timeout = r.to;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    job_mode = 1'($urandom); serial_base = 8'($urandom); systolic_base = 6'($urandom);
    tile_stride = 6'($urandom); num_tiles_m1 = 2'($urandom); timeout = 8'($urandom_range(1, 2));
  endtask

  task automatic run_job(input string name, input row_t r);
    bit seen_idle;
    push_expect(r);
    launch(r);
    seen_idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin seen_idle = 1'b1; break; end
    end
    chk({name, "_reaches_idle"}, seen_idle, 1);
    repeat (2) @(negedge clk);
    chk({name, "_err"}, err, r.exp_err);
    chk({name, "_pending_events"}, exq.size(), 0);
    exq.delete();
    resp_stray = 1'b0;
  endtask

  function automatic logic [23:0] outs();
    return {serial_mode_en, Weight_Preloader_en, Feature_Loader_en, systolic_mode,
            c_reg_sel, computation_mode_sel, serial_mode_feature_baseaddr,
            systolic_mode_feature_baseaddr, busy, job_done, err};
  endfunction

  row_t tbl[9];

  initial begin
    bit found;
    row_t r;
    //            mode  sb     yb     st     nt    to     dly stray err
    tbl[0] = '{1'b0, 8'h40, 6'h00, 6'h00, 2'd0, 8'd0, 5, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 6'h10, 6'h08, 2'd3, 8'd0, 3, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h00, 6'h3C, 6'h08, 2'd1, 8'd0, 2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h81, 6'h00, 6'h00, 2'd0, 8'd5, 5, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h00, 6'h05, 6'h3F, 2'd1, 8'd0, 2, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 6'h2A, 6'h15, 2'd0, 8'd4, 4, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h11, 6'h00, 6'h00, 2'd0, 8'd3, 0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h33, 6'h00, 6'h00, 2'd0, 8'd0, 2, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h00, 6'h00, 6'h01, 2'd2, 8'd2, 0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b1; abort = 1'b1; job_mode = 1'b1;
    serial_base = 8'hFF; systolic_base = 6'h3F; tile_stride = 6'h01;
    num_tiles_m1 = 2'd3; timeout = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs(), 0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", outs(), 0);
    mon_on = 1'b1;

    foreach (tbl[k]) run_job($sformatf("row%0d", k), tbl[k]);

    // abort + start together in IDLE: stay idle, err (set by row 8) kept
    @(negedge clk);
    abort = 1'b1; start = 1'b1; job_mode = 1'b0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle_busy", busy, 0);
    chk("abort_start_idle_err", err, 1);
    @(negedge clk);
    chk("abort_start_idle_busy2", busy, 0);

    // abort during tile 2, with an ignored start pulse during tile 1
    r = '{1'b1, 8'h00, 6'h10, 6'h08, 2'd3, 8'd0, 4, 1'b0, 1'b0};
    push_ev(1, 'h10, 0, 1, 4, 255);
    push_ev(2, 'h10, 0, 1, 4, 1);
    push_ev(2, 'h18, 1, 1, 4, 1);
    push_ev(2, 'h20, 2, 1, 2, 1);
    launch(r);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Feature_Loader_en && c_reg_sel == 2'd1) begin found = 1'b1; break; end
    end
    chk("abort_seq_tile1_seen", found, 1);
    start = 1'b1; job_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Feature_Loader_en && c_reg_sel == 2'd2) begin found = 1'b1; break; end
    end
    chk("abort_seq_tile2_seen", found, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_enables", {serial_mode_en, Weight_Preloader_en, Feature_Loader_en}, 0);
    chk("abort_job_done", job_done, 0);
    repeat (3) @(negedge clk);
    chk("abort_err_cleared_by_start", err, 0);
    chk("abort_pending_events", exq.size(), 0);
    exq.delete();

    // reset in the middle of the first feature tile
    r = '{1'b1, 8'h00, 6'h10, 6'h08, 2'd1, 8'd0, 4, 1'b0, 1'b0};
    push_ev(1, 'h10, 0, 1, 4, 255);
    push_ev(2, 'h10, 0, 1, 1, 1);
    launch(r);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Feature_Loader_en) begin found = 1'b1; break; end
    end
    chk("rst_seq_f_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_job_outputs_zero", outs(), 0);
    repeat (2) @(negedge clk);
    chk("rst_pending_events", exq.size(), 0);
    exq.delete();
    run_job("after_rst", tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/compute_sequencer.md
COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter TO_W, default 8, width of the per-step timeout counter and the timeout input.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  single-cycle job request; honoured only in IDLE.
REQ-005 abort  input  1  cancels any running job.
REQ-006 job_mode  input  1  selects the job type: 0 = serial, 1 = systolic.
REQ-007 serial_base  input  8  serial feature base address.
REQ-008 systolic_base  input  6  base address of the first systolic feature tile.
REQ-009 tile_stride  input  6  address increment between systolic tiles.
REQ-010 num_tiles_m1  input  2  number of systolic feature tiles minus 1 (1..4 tiles).
REQ-011 timeout  input  TO_W  maximum number of cycles to wait for a done; 0 disables the timeout.
REQ-012 serial_mode_done, weight_Preloader_done, feature_Loader_done  input  1 each  completion levels from the computation module.
REQ-013 serial_mode_en, Weight_Preloader_en, Feature_Loader_en  output  1 each  engine enables.
REQ-014 systolic_mode  output  1  0 = weight preload, 1 = feature load.
REQ-015 c_reg_sel  output  2  result register select: 0 = c11, 1 = c12, 2 = c21, 3 = c22.
REQ-016 computation_mode_sel  output  1  memory port owner: 0 = serial, 1 = systolic.
REQ-017 serial_mode_feature_baseaddr  output  8.
REQ-018 systolic_mode_feature_baseaddr  output  6.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 job_done  output  1  one-cycle pulse when a job completes successfully.
REQ-021 err  output  1  sticky timeout flag; cleared by the next accepted start or by rst.

Function
REQ-022 The FSM SHALL have the states IDLE, SER_RUN, W_LOAD, W_GAP, F_LOAD, F_GAP and FIN.
REQ-023 In IDLE, start=1 SHALL latch all configuration inputs, clear err, and move to SER_RUN (job_mode=0) or W_LOAD (job_mode=1); configuration changes during a job have no effect.
REQ-024 start SHALL be ignored in every state other than IDLE.
REQ-025 SER_RUN: serial_mode_en=1, computation_mode_sel=0, and the serial base address output equals the latched serial_base.
REQ-026 W_LOAD: Weight_Preloader_en=1, systolic_mode=0, computation_mode_sel=1.
REQ-027 F_LOAD: Feature_Loader_en=1, systolic_mode=1, computation_mode_sel=1, c_reg_sel=tile index, systolic_mode_feature_baseaddr = systolic_base + tile index * tile_stride, modulo 64 (wrap-around; no carry out).
REQ-028 An enable SHALL be asserted on the first clock edge after entry and held as a level until its done signal is sampled high.
REQ-029 Once done is sampled, the enable SHALL be low in the next cycle.
REQ-030 Done inputs SHALL be ignored in any state whose enable is not asserted.
REQ-031 Transitions: SER_RUN + serial_mode_done -> FIN.
REQ-032 Transitions: W_LOAD + weight_Preloader_done -> W_GAP -> F_LOAD with tile index 0.
REQ-033 Transitions: F_LOAD + feature_Loader_done -> F_GAP; then F_GAP -> F_LOAD with tile index+1 if tile index < num_tiles_m1, otherwise F_GAP -> FIN.
REQ-034 The gap states SHALL last exactly 1 cycle with all enables low.
REQ-035 FIN SHALL last 1 cycle: job_done=1, then -> IDLE.
REQ-036 computation_mode_sel and c_reg_sel SHALL hold their last values in the gap states, FIN and IDLE.
REQ-037 Timeout: a counter SHALL reset on entry to each enable state and increment every cycle in that state; when it reaches timeout (with timeout≠0) and done is not yet sampled, the FSM SHALL set err=1, drop all enables and go to IDLE without pulsing job_done.
REQ-038 If done and the timeout occur in the same cycle, done SHALL win.
REQ-039 abort=1 in any state SHALL return the FSM to IDLE next cycle with all enables low and no job_done pulse; abort has priority over done and timeout; err is unchanged.
REQ-040 If abort and start are both high in IDLE, the block SHALL stay in IDLE.
REQ-041 At most one engine enable SHALL be high in any cycle.

Reset
REQ-042 rst=1 SHALL force IDLE, tile index 0 and timeout counter 0 on the next edge, overriding start and abort.
REQ-043 Under rst, every output SHALL be 0: all enables, systolic_mode, c_reg_sel, computation_mode_sel, both base addresses, busy, job_done and err.
REQ-044 rst asserted mid-job SHALL deassert the active enable in the next cycle.

Verification
REQ-045 Serial job: start, job_mode=0, serial_base=0x40, done 5 cycles after the enable rises -> serial_mode_en high 5 cycles, sel=0, base=0x40, job_done pulse 1 cycle after the enable falls.
REQ-046 Systolic, 4 tiles: systolic_base=0x10, stride=0x08 -> weight preload, then feature loads at 0x10/0x18/0x20/0x28 with c_reg_sel 0/1/2/3, one-cycle gaps, one job_done pulse.
REQ-047 Address wrap: systolic_base=0x3C, stride=0x08, num_tiles_m1=1 -> addresses 0x3C then 0x04.
REQ-048 Timeout: timeout=3, done never asserted -> enable drops after 3 cycles, err=1, no job_done; the next start clears err.
REQ-049 abort during tile 2, and a start pulse while busy -> IDLE next cycle, enables low, no job_done; the start while busy is ignored.
REQ-050 rst mid-F_LOAD -> all outputs 0 next cycle; a subsequent start runs a normal job.
